// File: rtl/dlx_pipeline_pkg.sv
// Shared DLX pipeline definitions: hazard controller state encoding and
// the hard-wired zero register address.
package dlx_pipeline_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LD_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_stat_counter.sv
// Free-running wrap-around event counter with enable; used for hazard
// statistics when HAZARD_STATS_EN is defined.
module hazard_stat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// DLX pipeline interlock: load-use bubbles, taken-branch flushes and data-memory
// wait freezes. Define HAZARD_STATS_EN to add stall/flush statistics counters.
module hazard_unit
  import dlx_pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 64
`ifdef HAZARD_STATS_EN
  , parameter int CNT_WIDTH    = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] id_addr_b,
  input  logic                      id_uses_a,
  input  logic                      id_uses_b,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_addr,
  input  logic                      id_ex_mem_rd,
  input  logic                      id_ex_reg_wr_ena,
  input  logic                      branch_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_stall,
  output logic                      ex_mem_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      mem_wb_bubble,
  output logic                      mem_timeout
`ifdef HAZARD_STATS_EN
  , output logic [CNT_WIDTH-1:0]    stall_cycles
  , output logic [CNT_WIDTH-1:0]    flush_count
`endif
);

  localparam int                        WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]         WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + WAIT_W'(1);
  endfunction

  hz_state_e         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              lu;
  logic              mw;
  logic              freeze;
  logic              br_flush;
  logic              ld_bubble;

  assign lu = id_ex_mem_rd & id_ex_reg_wr_ena & (id_ex_reg_addr != ZERO_ADDR) &
              ((id_uses_a & (id_addr_a == id_ex_reg_addr)) |
               (id_uses_b & (id_addr_b == id_ex_reg_addr)));
  assign mw       = dmem_req & ~dmem_ready;
  assign wait_nxt = sat_inc(wait_cnt);

  // The three actions are mutually exclusive, so no register is ever stalled
  // and flushed in the same cycle. Everything is forced low during reset.
  always_comb begin
    freeze    = 1'b0;
    br_flush  = 1'b0;
    ld_bubble = 1'b0;
    if (!rst) begin
      case (state)
        RUN, LD_BUBBLE: begin
          if (mw)                        freeze    = 1'b1;
          else if (branch_taken)         br_flush  = 1'b1;
          else if (state == RUN && lu)   ld_bubble = 1'b1;
        end
        MEM_WAIT: freeze = ~dmem_ready;
        default: ;
      endcase
    end
  end

  assign pc_stall      = freeze | ld_bubble;
  assign if_id_stall   = freeze | ld_bubble;
  assign id_ex_stall   = freeze;
  assign ex_mem_stall  = freeze;
  assign mem_wb_bubble = freeze;
  assign if_id_flush   = br_flush;
  assign id_ex_flush   = br_flush | ld_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (!branch_taken && lu) begin
            state <= LD_BUBBLE;
          end
        end
        LD_BUBBLE: begin
          if (mw) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else begin
            state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_stall),
    .count (stall_cycles)
  );

  hazard_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (if_id_flush),
    .count (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MAX_WAIT=4, CNT_WIDTH=4); the statistics
// checks are built only when HAZARD_STATS_EN is defined.
module tb_hazard_unit;
  import dlx_pipeline_pkg::*;

  localparam int AW = 5;
`ifdef HAZARD_STATS_EN
  localparam int CW = 4;
`endif

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1111001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LU   = 7'b1100010;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          ua;
    logic          ub;
    logic [AW-1:0] exa;
    logic          rd;
    logic          wr;
    logic          br;
    logic          req;
    logic          rdy;
    logic [6:0]    ctl;
    logic          mto;
  } stim_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] id_addr_a = '0, id_addr_b = '0, id_ex_reg_addr = '0;
  logic          id_uses_a = 1'b0, id_uses_b = 1'b0;
  logic          id_ex_mem_rd = 1'b0, id_ex_reg_wr_ena = 1'b0;
  logic          branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic          if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_ADDR_WIDTH (AW),
    .MAX_WAIT       (4)
`ifdef HAZARD_STATS_EN
    , .CNT_WIDTH    (CW)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_addr_a        (id_addr_a),
    .id_addr_b        (id_addr_b),
    .id_uses_a        (id_uses_a),
    .id_uses_b        (id_uses_b),
    .id_ex_reg_addr   (id_ex_reg_addr),
    .id_ex_mem_rd     (id_ex_mem_rd),
    .id_ex_reg_wr_ena (id_ex_reg_wr_ena),
    .branch_taken     (branch_taken),
    .dmem_req         (dmem_req),
    .dmem_ready       (dmem_ready),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .id_ex_stall      (id_ex_stall),
    .ex_mem_stall     (ex_mem_stall),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .mem_wb_bubble    (mem_wb_bubble),
    .mem_timeout      (mem_timeout)
`ifdef HAZARD_STATS_EN
    , .stall_cycles   (stall_cycles)
    , .flush_count    (flush_count)
`endif
  );

  function automatic stim_t mk(input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic ua, input logic ub, input logic [AW-1:0] exa,
                               input logic rd, input logic wr, input logic br,
                               input logic req, input logic rdy,
                               input logic [6:0] ctl, input logic mto);
    stim_t s;
    s.a = a; s.b = b; s.ua = ua; s.ub = ub; s.exa = exa;
    s.rd = rd; s.wr = wr; s.br = br; s.req = req; s.rdy = rdy;
    s.ctl = ctl; s.mto = mto;
    return s;
  endfunction

  function automatic logic [7:0] observed();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout};
  endfunction

  task automatic drive(input stim_t s);
    id_addr_a = s.a; id_addr_b = s.b; id_uses_a = s.ua; id_uses_b = s.ub;
    id_ex_reg_addr = s.exa; id_ex_mem_rd = s.rd; id_ex_reg_wr_ena = s.wr;
    branch_taken = s.br; dmem_req = s.req; dmem_ready = s.rdy;
  endtask

  // Drive one cycle's inputs after the edge, queue the expectation, sample mid-cycle.
  task automatic run_step(input stim_t s, output logic [7:0] got);
    @(posedge clk);
    #1;
    drive(s);
    sb.push_back({s.ctl, s.mto});
    @(negedge clk);
    got = observed();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    logic [7:0] want;
    #2;
    drive(mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 1, 1, 0, C_NONE, 0));
    rst = 1'b1;
    #1;
    got = observed();
    n_vec++;
    if (got !== 8'h00) begin n_err++; $display("FAIL reset_outputs: got %b want %b", got, 8'h00); end
    n_vec++;
    if (dut.state !== RUN) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state, RUN); end
    n_vec++;
    if (dut.wait_cnt !== '0) begin n_err++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.wait_cnt); end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0), got);
    want = sb.pop_front();
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_idle: got %b want %b", got, want); end
  endtask

  task automatic test_load_use();
    stim_t      tbl[$];
    logic [7:0] got;
    logic [7:0] want;
    tbl.push_back(mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 0, 0, 0, C_LU,   0));  // lw r3 / add r5,r3,r4
    tbl.push_back(mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 0, 0, 0, C_NONE, 0));  // bubble cycle: lu masked
    tbl.push_back(mk(5'd3, 5'd4, 1, 1, 5'd9, 0, 1, 0, 0, 0, C_NONE, 0));
    tbl.push_back(mk(5'd7, 5'd4, 1, 1, 5'd4, 1, 1, 0, 0, 0, C_LU,   0));  // match on b
    tbl.push_back(mk(5'd7, 5'd4, 1, 1, 5'd1, 0, 0, 0, 0, 0, C_NONE, 0));
    tbl.push_back(mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, C_NONE, 0));  // load to r0
    tbl.push_back(mk(5'd6, 5'd2, 0, 1, 5'd6, 1, 1, 0, 0, 0, C_NONE, 0));  // a not used
    tbl.push_back(mk(5'd6, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0, 0, C_NONE, 0));  // no write enable
    tbl.push_back(mk(5'd6, 5'd2, 1, 1, 5'd6, 0, 1, 0, 0, 0, C_NONE, 0));  // not a load
    for (int i = 0; i < tbl.size(); i++) begin
      run_step(tbl[i], got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL load_use[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_branch();
    stim_t      tbl[$];
    logic [7:0] got;
    logic [7:0] want;
    tbl.push_back(mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 1, 0, 0, C_BR,   0));  // branch beats lu
    tbl.push_back(mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 0, 0, 0, C_LU,   0));  // still RUN, so lu fires
    tbl.push_back(mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 1, 0, 0, C_BR,   0));  // branch in LD_BUBBLE
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, C_FRZ,  0));  // mem wait beats branch
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, C_NONE, 0));
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, C_NONE, 0));  // ready without req
    for (int i = 0; i < tbl.size(); i++) begin
      run_step(tbl[i], got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL branch[%0d]: got %b want %b", i, got, want); end
      if (i == 0) begin
        n_vec++;
        @(posedge clk);
        #1;
        if (dut.state !== RUN) begin n_err++; $display("FAIL branch_state: got %0d want %0d", dut.state, RUN); end
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t      tbl[$];
    logic [7:0] got;
    logic [7:0] want;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] c0 = '0;
`endif
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  0));  // branch ignored while frozen
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_NONE, 0));  // release cycle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,   0));  // branch acted on in RUN
    for (int i = 0; i < tbl.size(); i++) begin
      run_step(tbl[i], got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL mem_wait[%0d]: got %b want %b", i, got, want); end
`ifdef HAZARD_STATS_EN
      if (i == 0) c0 = stall_cycles;
      if (i == 3) begin
        n_vec++;
        if (stall_cycles !== c0 + CW'(3)) begin
          n_err++;
          $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, c0 + CW'(3));
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    stim_t      tbl[$];
    logic [7:0] got;
    logic [7:0] want;
    tbl.push_back(mk(5'd8, 5'd1, 1, 0, 5'd8, 1, 1, 0, 0, 0, C_LU,   0));
    tbl.push_back(mk(5'd8, 5'd1, 1, 0, 5'd8, 1, 1, 0, 1, 0, C_FRZ,  0));  // wait during bubble
    tbl.push_back(mk(5'd8, 5'd1, 1, 0, 5'd8, 1, 1, 0, 1, 1, C_NONE, 0));
    tbl.push_back(mk(5'd8, 5'd1, 1, 0, 5'd8, 1, 1, 0, 0, 0, C_LU,   0));
    tbl.push_back(mk(5'd8, 5'd1, 1, 0, 5'd8, 1, 1, 0, 0, 0, C_NONE, 0));
    tbl.push_back(mk(5'd8, 5'd1, 1, 0, 5'd8, 1, 1, 0, 0, 0, C_LU,   0));
    for (int i = 0; i < tbl.size(); i++) begin
      run_step(tbl[i], got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_timeout();
    stim_t      tbl[$];
    logic [7:0] got;
    logic [7:0] want;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, (k >= 5) ? 1'b1 : 1'b0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
    tbl.push_back(mk(5'd2, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0, 0, C_LU, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      run_step(tbl[i], got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL timeout[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t      tbl[$];
    logic [7:0] got;
    logic [7:0] want;
    run_step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1), got);
    want = sb.pop_front();
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL rst_mid_pre0: got %b want %b", got, want); end
    run_step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1), got);
    want = sb.pop_front();
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL rst_mid_pre1: got %b want %b", got, want); end
    rst = 1'b1;
    #1;
    got = observed();
    n_vec++;
    if (got !== 8'h00) begin n_err++; $display("FAIL rst_mid_outputs: got %b want %b", got, 8'h00); end
    n_vec++;
    if (dut.state !== RUN) begin n_err++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state, RUN); end
    n_vec++;
    if (dut.wait_cnt !== '0) begin n_err++; $display("FAIL rst_mid_wait_cnt: got %0d want 0", dut.wait_cnt); end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tbl.push_back(mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, C_LU,   0));
    tbl.push_back(mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, C_NONE, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      run_step(tbl[i], got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL rst_mid_resume[%0d]: got %b want %b", i, got, want); end
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_flush_wrap();
    logic [7:0] got;
    logic [7:0] want;
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (flush_count !== '0) begin n_err++; $display("FAIL flush_count_reset: got %0d want 0", flush_count); end
    for (int i = 0; i < 18; i++) begin
      run_step(mk(0, 0, 0, 0, 0, 0, 0, (i < 17) ? 1'b1 : 1'b0, 0, 0,
                  (i < 17) ? C_BR : C_NONE, 0), got);
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL flush_wrap[%0d]: got %b want %b", i, got, want); end
    end
    n_vec++;
    if (flush_count !== CW'(1)) begin n_err++; $display("FAIL flush_count_wrap: got %0d want 1", flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
`ifdef HAZARD_STATS_EN
    test_flush_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the DLX core: the interlock counterpart to the execute-stage forwarding logic. It detects hazards that operand forwarding cannot resolve and drives the stall, bubble and flush controls of the pipeline registers. Covered cases are load-use dependencies, taken branches resolved in EX, and data-memory wait states. It sits beside the decode stage and sees the ID, ID/EX, EX and MEM pipeline fields.

## Interface
- `REG_ADDR_WIDTH`, 5, register address width.
- `MAX_WAIT`, 64, MEM_WAIT cycle count at which `mem_timeout` sets (≥2).
- `CNT_WIDTH`, 16, width of the statistics counters (only when stats are compiled in).

Ports:
- `clk`  in  1  clock. Logic is rising-edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `id_addr_a`, `id_addr_b`  in  REG_ADDR_WIDTH  source registers of the instruction in ID.
- `id_uses_a`, `id_uses_b`  in  1  ID instruction actually reads a / b.
- `id_ex_reg_addr`  in  REG_ADDR_WIDTH  destination of the instruction in EX.
- `id_ex_mem_rd`  in  1  instruction in EX is a load.
- `id_ex_reg_wr_ena`  in  1  instruction in EX writes the register file.
- `branch_taken`  in  1  taken branch/jump resolved in EX this cycle.
- `dmem_req`  in  1  MEM stage is issuing a data-memory access.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1  hold the named register.
- `if_id_flush`, `id_ex_flush`  out  1  load a NOP into the named register.
- `mem_wb_bubble`  out  1  load a NOP into MEM/WB.
- `mem_timeout`  out  1  sticky memory-timeout flag.
- `stall_cycles`, `flush_count`  out  CNT_WIDTH  statistics (HAZARD_STATS_EN only).

## Operation
- Load-use hazard (`lu`) = `id_ex_mem_rd & id_ex_reg_wr_ena & (id_ex_reg_addr != 0) & ((id_uses_a & id_addr_a == id_ex_reg_addr) | (id_uses_b & id_addr_b == id_ex_reg_addr))`.
- Register 0 never creates a hazard.
- Mem wait (`mw`) = `dmem_req & !dmem_ready`.
- States: RUN, LD_BUBBLE, MEM_WAIT. Control outputs are combinational from state and inputs.
- RUN, checks in priority order:
  - `mw`: assert all four stalls plus `mem_wb_bubble`. Next state MEM_WAIT, `wait_cnt` set to 1.
  - `branch_taken`: assert `if_id_flush` and `id_ex_flush`. Stay in RUN; `lu` is ignored because the ID instruction is discarded.
  - `lu`: assert `pc_stall`, `if_id_stall` and `id_ex_flush` (one bubble). Next state LD_BUBBLE.
  - None of the above: all outputs 0.
- LD_BUBBLE: same as RUN except `lu` is masked. After one cycle go to RUN; if `mw` is true, go to MEM_WAIT instead.
- MEM_WAIT:
  - While `!dmem_ready`: keep the full freeze and increment `wait_cnt`, saturating at MAX_WAIT.
  - When `wait_cnt == MAX_WAIT`: set `mem_timeout` (sticky until reset) and keep waiting.
  - `dmem_ready=1`: all outputs 0 in that cycle; next state RUN.
  - `branch_taken` is ignored in MEM_WAIT. EX is frozen, so the branch is acted on in the first RUN cycle.
- Never assert stall and flush on the same register in the same cycle.

## Timing
- Reset: state RUN, `wait_cnt` 0, `mem_timeout` 0, counters 0.
- While `rst` is high, every output is forced to 0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately.
- Control outputs: zero latency. They are combinational in the cycle the condition appears and are sampled by the pipeline registers at the next edge.
- Load-use costs exactly 1 bubble cycle.
- Taken branch costs 2 flushed slots in one cycle.
- A mem wait of N not-ready cycles freezes the pipe N cycles; release happens in the cycle `dmem_ready` rises.
- `dmem_ready` with `dmem_req` low is don't-care.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_stall=1`.
  - `flush_count` increments on every cycle with `if_id_flush=1`.
  - Both wrap modulo 2^CNT_WIDTH and clear on reset.
- Undefined: the counters and their ports are absent.

## Structure
- Shared package `dlx_pipeline_pkg`: state encoding (RUN=2'd0, LD_BUBBLE=2'd1, MEM_WAIT=2'd2) and the `REG_ZERO` address constant.
- Sub-module `hazard_stat_counter`: one CNT_WIDTH wrap-around counter with enable. Instantiated twice, under `HAZARD_STATS_EN` only.

## Test plan
- Load-use, `lw r3` in EX and `add r5,r3,r4` in ID:
  - `pc_stall`/`if_id_stall`/`id_ex_flush`=1 for exactly 1 cycle, then 0.
  - Load to r0 with a matching ID source: no stall.
- `branch_taken`=1 in RUN while `lu` is also true: only `if_id_flush` and `id_ex_flush` assert, state stays RUN.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles:
  - Full freeze plus `mem_wb_bubble` for 3 cycles, released in the ready cycle.
  - `stall_cycles` rises by 3.
- MAX_WAIT=4, `dmem_ready` held low for 6 cycles:
  - `mem_timeout` sets after 4 cycles and stays 1 after release.
  - It clears only on `rst`.
- `rst` pulsed during MEM_WAIT: outputs 0 immediately, state RUN, `wait_cnt` 0. Normal operation resumes after deassertion.
- `HAZARD_STATS_EN` with CNT_WIDTH=4: 17 flush cycles -> `flush_count` = 1 (wrap).
